// File: rtl/sass_pkg.sv
// ============================================================================
// Module   : sass_pkg
// Brief    : Shared note codes, beat encoding and conductor state type for the
//            step sequencer. Optional macro: SASS_CONDUCTOR_SWING_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sass_pkg;

    localparam logic [3:0] NOTE_OFF    = 4'd0;
    localparam logic [3:0] NOTE_C      = 4'd1;
    localparam logic [3:0] NOTE_CS     = 4'd2;
    localparam logic [3:0] NOTE_D      = 4'd3;
    localparam logic [3:0] NOTE_DS     = 4'd4;
    localparam logic [3:0] NOTE_E      = 4'd5;
    localparam logic [3:0] NOTE_F      = 4'd6;
    localparam logic [3:0] NOTE_FS     = 4'd7;
    localparam logic [3:0] NOTE_G      = 4'd8;
    localparam logic [3:0] NOTE_GS     = 4'd9;
    localparam logic [3:0] NOTE_A      = 4'd10;
    localparam logic [3:0] NOTE_AS     = 4'd11;
    localparam logic [3:0] NOTE_B      = 4'd12;
    localparam logic [3:0] NOTE_HIGH_C = 4'd13;

    localparam logic [3:0] BEAT_STOPPED = 4'hF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } conductor_state_t;

    // Swung beat length: even beats stretch, odd beats shrink by a quarter.
    function automatic int swing_beat_len(input int tempo_div, input bit odd);
        return odd ? (tempo_div - tempo_div / 4) : (tempo_div + tempo_div / 4);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sequencer_conductor_tempo_timer.sv
// ============================================================================
// Module   : tempo_timer
// Brief    : Beat-length counter emitting a one-cycle tick at terminal count.
//            Optional macro: SASS_CONDUCTOR_SWING_EN (alternating beat length).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tempo_timer
    import sass_pkg::*;
#(
    parameter int TEMPO_DIV = 2500
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    input  logic odd_beat,
    output logic beat_tick
);

    localparam int CNT_W = $clog2(2 * TEMPO_DIV);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] last_cnt;

`ifdef SASS_CONDUCTOR_SWING_EN
    localparam int LONG_LEN  = swing_beat_len(TEMPO_DIV, 1'b0);
    localparam int SHORT_LEN = swing_beat_len(TEMPO_DIV, 1'b1);
    assign last_cnt = odd_beat ? CNT_W'(SHORT_LEN - 1) : CNT_W'(LONG_LEN - 1);
`else
    logic unused_odd_beat;
    assign unused_odd_beat = odd_beat;
    assign last_cnt        = CNT_W'(TEMPO_DIV - 1);
`endif

    assign beat_tick = enable && (count_q == last_cnt);

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = beat_tick ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sequencer_conductor.sv
// ============================================================================
// Module   : sequencer_conductor
// Brief    : Step-sequencer scheduler: beat generation, run/stop, edit cursor,
//            toggle steering and piano/sequencer note arbitration.
//            Optional macro: SASS_CONDUCTOR_SWING_EN (swung beat lengths).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequencer_conductor
    import sass_pkg::*;
#(
    parameter int NUM_STEPS   = 8,
    parameter int TEMPO_DIV   = 2500,
    parameter int SUSTAIN_CYC = 1000
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         sequencer_on,
    input  logic                         run_pb,
    input  logic                         next_pb,
    input  logic                         toggle_pb,
    input  logic [3:0]                   piano_note,
    input  logic [4*NUM_STEPS-1:0]       step_notes,
    output logic [3:0]                   beat,
    output logic [NUM_STEPS-1:0]         step_toggle,
    output logic [$clog2(NUM_STEPS)-1:0] cursor,
    output logic                         playing,
    output logic [3:0]                   note_out
);

    localparam int CW = $clog2(NUM_STEPS);
    localparam int SW = $clog2(SUSTAIN_CYC + 1);

    conductor_state_t     state_q, state_d;
    logic [3:0]           beat_q, beat_d;
    logic [CW-1:0]        cursor_q, cursor_d;
    logic [NUM_STEPS-1:0] step_toggle_q, step_toggle_d;
    logic [3:0]           note_out_q, note_out_d;
    logic [SW-1:0]        sustain_q, sustain_d;
    logic [3:0]           latched_q, latched_d;

    logic          beat_tick;
    logic          run_start;
    logic          run_stop;
    logic [CW-1:0] next_idx;
    logic [CW-1:0] load_idx;
    logic [3:0]    load_note;
    logic [SW-1:0] sustain_load;

    tempo_timer #(
        .TEMPO_DIV (TEMPO_DIV)
    ) u_tempo_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (state_q != RUN),
        .enable    (state_q == RUN),
        .odd_beat  (beat_q[0]),
        .beat_tick (beat_tick)
    );

    assign run_start = (state_q == IDLE) && sequencer_on && run_pb;
    assign run_stop  = (state_q == RUN) && (!sequencer_on || run_pb);
    assign next_idx  = beat_q[CW-1:0] + CW'(1);
    assign load_idx  = run_start ? '0 : next_idx;
    assign load_note = step_notes[{load_idx, 2'b00} +: 4];

`ifdef SASS_CONDUCTOR_SWING_EN
    // Only the shortened odd beats can be shorter than the sustain time.
    localparam int SHORT_LEN = swing_beat_len(TEMPO_DIV, 1'b1);
    localparam int SUS_ODD   = (SUSTAIN_CYC > SHORT_LEN) ? SHORT_LEN : SUSTAIN_CYC;
    assign sustain_load = load_idx[0] ? SW'(SUS_ODD) : SW'(SUSTAIN_CYC);
`else
    assign sustain_load = SW'(SUSTAIN_CYC);
`endif

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        latched_d = latched_q;
        sustain_d = (sustain_q != '0) ? sustain_q - SW'(1) : '0;

        // Stop takes precedence over a coincident beat tick.
        if (run_start) begin
            state_d   = RUN;
            beat_d    = 4'd0;
            latched_d = load_note;
            sustain_d = sustain_load;
        end else if (run_stop) begin
            state_d   = IDLE;
            beat_d    = BEAT_STOPPED;
            latched_d = NOTE_OFF;
            sustain_d = '0;
        end else if ((state_q == RUN) && beat_tick) begin
            beat_d    = 4'(next_idx);
            latched_d = load_note;
            sustain_d = sustain_load;
        end

        cursor_d      = (sequencer_on && next_pb) ? cursor_q + CW'(1) : cursor_q;
        step_toggle_d = (sequencer_on && toggle_pb) ? (NUM_STEPS'(1) << cursor_q) : '0;

        if (piano_note != NOTE_OFF) begin
            note_out_d = piano_note;
        end else if ((state_q == RUN) && (sustain_q != '0)) begin
            note_out_d = latched_q;
        end else begin
            note_out_d = NOTE_OFF;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            state_q       <= IDLE;
            beat_q        <= BEAT_STOPPED;
            cursor_q      <= '0;
            step_toggle_q <= '0;
            note_out_q    <= NOTE_OFF;
            sustain_q     <= '0;
            latched_q     <= NOTE_OFF;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            cursor_q      <= cursor_d;
            step_toggle_q <= step_toggle_d;
            note_out_q    <= note_out_d;
            sustain_q     <= sustain_d;
            latched_q     <= latched_d;
        end
    end

    assign beat        = beat_q;
    assign step_toggle = step_toggle_q;
    assign cursor      = cursor_q;
    assign playing     = (state_q == RUN);
    assign note_out    = note_out_q;

endmodule

`default_nettype wire

// File: tb/tb_sequencer_conductor.sv
// ============================================================================
// Module   : tb_sequencer_conductor
// Brief    : Self-checking bench for sequencer_conductor against a
//            time-since-start reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequencer_conductor;

    localparam int N = 8;
    localparam int T = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           n_rst;
    logic           sequencer_on;
    logic           run_pb;
    logic           next_pb;
    logic           toggle_pb;
    logic [3:0]     piano_note;
    logic [4*N-1:0] step_notes;
    logic [3:0]     beat;
    logic [N-1:0]   step_toggle;
    logic [2:0]     cursor;
    logic           playing;
    logic [3:0]     note_out;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: position in the pattern is elapsed cycles since start.
    bit         m_run;
    int         m_el;
    int         m_cur;
    logic [3:0] m_latch;
    logic [3:0] e_note;
    logic [N-1:0] e_toggle;

    sequencer_conductor #(
        .NUM_STEPS   (N),
        .TEMPO_DIV   (T),
        .SUSTAIN_CYC (S)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .sequencer_on (sequencer_on),
        .run_pb       (run_pb),
        .next_pb      (next_pb),
        .toggle_pb    (toggle_pb),
        .piano_note   (piano_note),
        .step_notes   (step_notes),
        .beat         (beat),
        .step_toggle  (step_toggle),
        .cursor       (cursor),
        .playing      (playing),
        .note_out     (note_out)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_beat();
        return m_run ? 4'((m_el / T) % N) : 4'hF;
    endfunction

    function automatic logic [3:0] note_of(input int i);
        return step_notes[4*i +: 4];
    endfunction

    task automatic model_reset();
        m_run = 0; m_el = 0; m_cur = 0; m_latch = 4'd0; e_note = 4'd0; e_toggle = '0;
    endtask

    task automatic model_tick();
        e_note   = (piano_note != 4'd0) ? piano_note :
                   ((m_run && (m_el % T) < S) ? m_latch : 4'd0);
        e_toggle = (sequencer_on && toggle_pb) ? (N'(1) << m_cur) : '0;
        if (sequencer_on && next_pb) m_cur = (m_cur + 1) % N;
        if (m_run) begin
            if (!sequencer_on || run_pb) begin
                m_run = 0; m_latch = 4'd0;
            end else begin
                m_el++;
                if (m_el % T == 0) m_latch = note_of((m_el / T) % N);
            end
        end else if (sequencer_on && run_pb) begin
            m_run = 1; m_el = 0; m_latch = note_of(0);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_run();
        run_pb = 1'b1;
        cycle();
        run_pb = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({beat, playing, cursor, step_toggle, note_out} !== {4'hF, 1'b0, 3'd0, 8'h00, 4'h0}) begin
            tests_failed++;
            $display("FAIL reset: got beat=%h play=%b cur=%0d tog=%b note=%h, want F/0/0/0/0",
                     beat, playing, cursor, step_toggle, note_out);
        end
    endtask

    task automatic test_run_beats();
        sequencer_on = 1'b1;
        pulse_run();
        tests_run++;
        if (playing !== 1'b1 || beat !== 4'd0) begin
            tests_failed++;
            $display("FAIL run_start: got play=%b beat=%h, want 1/0", playing, beat);
        end
        for (int k = 1; k <= 36; k++) begin
            cycle();
            tests_run++;
            if (beat !== 4'((k / T) % N) || playing !== 1'b1) begin
                tests_failed++;
                $display("FAIL beat_seq k=%0d: got beat=%h play=%b, want %0d/1", k, beat, playing, (k / T) % N);
            end
        end
        pulse_run();
    endtask

    task automatic test_notes();
        logic [3:0] exp_seq [12];
        exp_seq = '{4'd0, 4'd5, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 4'd8, 4'd0};
        step_notes = 32'h8888_8805;
        pulse_run();
        for (int k = 0; k < 12; k++) begin
            if (k > 0) cycle();
            tests_run++;
            if (note_out !== exp_seq[k]) begin
                tests_failed++;
                $display("FAIL note_seq k=%0d: got %h want %h", k, note_out, exp_seq[k]);
            end
        end
        pulse_run();
    endtask

    task automatic test_cursor_toggle();
        do_reset();
        sequencer_on = 1'b1;
        next_pb = 1'b1;
        repeat (3) cycle();
        next_pb = 1'b0;
        tests_run++;
        if (cursor !== 3'd3) begin
            tests_failed++;
            $display("FAIL cursor3: got %0d want 3", cursor);
        end
        toggle_pb = 1'b1;
        cycle();
        toggle_pb = 1'b0;
        tests_run++;
        if (step_toggle !== 8'b0000_1000) begin
            tests_failed++;
            $display("FAIL toggle_at3: got %b want 00001000", step_toggle);
        end
        cycle();
        tests_run++;
        if (step_toggle !== 8'h00) begin
            tests_failed++;
            $display("FAIL toggle_one_cycle: got %b want 00000000", step_toggle);
        end
        next_pb = 1'b1;
        repeat (5) cycle();
        next_pb = 1'b0;
        tests_run++;
        if (cursor !== 3'd0) begin
            tests_failed++;
            $display("FAIL cursor_wrap: got %0d want 0", cursor);
        end
        next_pb = 1'b1; toggle_pb = 1'b1;
        cycle();
        next_pb = 1'b0; toggle_pb = 1'b0;
        tests_run++;
        if (step_toggle !== 8'h01 || cursor !== 3'd1) begin
            tests_failed++;
            $display("FAIL toggle_old_cursor: got tog=%b cur=%0d want 00000001/1", step_toggle, cursor);
        end
        sequencer_on = 1'b0; toggle_pb = 1'b1; next_pb = 1'b1;
        cycle();
        toggle_pb = 1'b0; next_pb = 1'b0; sequencer_on = 1'b1;
        tests_run++;
        if (step_toggle !== 8'h00 || cursor !== 3'd1) begin
            tests_failed++;
            $display("FAIL piano_mode_gate: got tog=%b cur=%0d want 00000000/1", step_toggle, cursor);
        end
    endtask

    task automatic test_piano_priority();
        int n;
        step_notes = 32'h8888_8888;
        pulse_run();
        n = 0;
        while (note_out !== 4'd8 && n < 20) begin cycle(); n++; end
        tests_run++;
        if (note_out !== 4'd8) begin
            tests_failed++;
            $display("FAIL wait_note8: got %h want 8 (timeout)", note_out);
        end
        piano_note = 4'd3;
        cycle();
        tests_run++;
        if (note_out !== 4'd3) begin
            tests_failed++;
            $display("FAIL piano_override: got %h want 3", note_out);
        end
        piano_note = 4'd0;
        cycle();
        tests_run++;
        if (note_out !== e_note) begin
            tests_failed++;
            $display("FAIL piano_release: got %h want %h", note_out, e_note);
        end
    endtask

    task automatic test_stop_at_wrap();
        int n;
        n = 0;
        while (!(m_run && exp_beat() == 4'd7 && (m_el % T) == T - 1) && n < 100) begin cycle(); n++; end
        tests_run++;
        if (beat !== 4'd7) begin
            tests_failed++;
            $display("FAIL wait_beat7: got %h want 7 (timeout)", beat);
        end
        pulse_run();
        tests_run++;
        if ({playing, beat, note_out} !== {1'b0, 4'hF, 4'h0}) begin
            tests_failed++;
            $display("FAIL stop_at_wrap: got play=%b beat=%h note=%h want 0/F/0", playing, beat, note_out);
        end
        cycle();
        tests_run++;
        if ({playing, beat, note_out} !== {1'b0, 4'hF, 4'h0}) begin
            tests_failed++;
            $display("FAIL no_latch_after_stop: got play=%b beat=%h note=%h want 0/F/0", playing, beat, note_out);
        end
        pulse_run();
        repeat (3) cycle();
        sequencer_on = 1'b0;
        cycle();
        sequencer_on = 1'b1;
        tests_run++;
        if (playing !== 1'b0 || beat !== 4'hF) begin
            tests_failed++;
            $display("FAIL seq_off_stops: got play=%b beat=%h want 0/F", playing, beat);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            sequencer_on = ($urandom_range(0, 19) != 0);
            run_pb       = ($urandom_range(0, 11) == 0);
            next_pb      = ($urandom_range(0, 3) == 0);
            toggle_pb    = ($urandom_range(0, 2) == 0);
            piano_note   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 13)) : 4'd0;
            if ($urandom_range(0, 24) == 0) step_notes = $urandom;
            cycle();
            tests_run++;
            if ({beat, playing, cursor, step_toggle, note_out} !==
                {exp_beat(), m_run, 3'(m_cur), e_toggle, e_note}) begin
                tests_failed++;
                $display("FAIL random i=%0d: got beat=%h play=%b cur=%0d tog=%b note=%h want beat=%h play=%b cur=%0d tog=%b note=%h",
                         i, beat, playing, cursor, step_toggle, note_out,
                         exp_beat(), m_run, m_cur, e_toggle, e_note);
            end
        end
        sequencer_on = 1'b1; run_pb = 1'b0; next_pb = 1'b0; toggle_pb = 1'b0; piano_note = 4'd0;
    endtask

    task automatic test_async_reset();
        int n;
        do_reset();
        next_pb = 1'b1;
        repeat (6) cycle();
        next_pb = 1'b0;
        pulse_run();
        n = 0;
        while (beat !== 4'd4 && n < 40) begin cycle(); n++; end
        cycle();
        tests_run++;
        if (beat !== 4'd4 || cursor !== 3'd6) begin
            tests_failed++;
            $display("FAIL pre_async: got beat=%h cur=%0d want 4/6", beat, cursor);
        end
        #2;
        n_rst = 1'b1;
        #1;
        tests_run++;
        if ({beat, playing, cursor, step_toggle, note_out} !== {4'hF, 1'b0, 3'd0, 8'h00, 4'h0}) begin
            tests_failed++;
            $display("FAIL async_reset: got beat=%h play=%b cur=%0d tog=%b note=%h want F/0/0/0/0",
                     beat, playing, cursor, step_toggle, note_out);
        end
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        n_rst = 1'b1; sequencer_on = 1'b0; run_pb = 1'b0; next_pb = 1'b0;
        toggle_pb = 1'b0; piano_note = 4'd0; step_notes = '0;
        model_reset();
        test_reset();
        test_run_beats();
        test_notes();
        test_cursor_toggle();
        test_piano_priority();
        test_stop_at_wrap();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
